// File: rtl/tinyneuron_pkg.sv
// Shared types, constants and output-stage helper for the TinyNeuron sequencer.
package tinyneuron_pkg;

  localparam int unsigned BYTE_W = 8;
  // Widest accumulator the output helper accepts; callers sign-extend into it.
  localparam int unsigned SAT_W  = 32;

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_X,
    LOAD_B,
    MAC,
    ACT,
    OUT
  } seq_state_t;

  // ReLU, arithmetic right shift, then clamp to 0..255.
  function automatic logic [BYTE_W-1:0] sat_u8(input logic signed [SAT_W-1:0] acc,
                                               input int unsigned shift);
    logic signed [SAT_W-1:0] r;
    logic [BYTE_W-1:0]       res;
    res = '0;
    r   = acc >>> shift;
    if (acc >= 0) res = (r > 255) ? 8'hFF : r[BYTE_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/tinyneuron_seq_if.sv
// Byte-in / byte-out valid-ready bundle between the I/O shim and the sequencer.
interface tinyneuron_seq_if;
  import tinyneuron_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] in_data;
  logic              reload_w;
  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;

  modport master (
    output in_valid, in_data, reload_w, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, reload_w, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tinyneuron_mac.sv
// Signed 8x8 multiply with an ACC_W-bit accumulator; bias load has priority over accumulate.
module tinyneuron_mac
  import tinyneuron_pkg::*;
#(
  parameter int unsigned ACC_W = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_load,
  input  logic                     en,
  input  logic signed [BYTE_W-1:0] bias,
  input  logic signed [BYTE_W-1:0] a,
  input  logic signed [BYTE_W-1:0] b,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [2*BYTE_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    r_acc;

  assign w_prod = a * b;
  assign acc    = r_acc;

  // Accumulator: seed with sign-extended bias, then add one product per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clr_load) begin
      r_acc <= ACC_W'(bias);
    end else if (en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

endmodule

// File: rtl/tinyneuron_seq.sv
// TinyNeuron sequencer: loads weights/activations/bias, time-shares one MAC, emits a u8 result.
module tinyneuron_seq
  import tinyneuron_pkg::*;
#(
  parameter int unsigned N_INPUTS = 4,
  parameter int unsigned ACC_W    = 20,
  parameter int unsigned SHIFT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  tinyneuron_seq_if.slave  bus,
  output logic             busy
);

  localparam int unsigned     IDX_W    = $clog2(N_INPUTS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUTS - 1);

  seq_state_t               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic signed [BYTE_W-1:0] r_w [N_INPUTS];
  logic signed [BYTE_W-1:0] r_x [N_INPUTS];
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [BYTE_W-1:0]        r_out_data;
  logic                     r_busy;

  logic                     w_xfer;
  logic                     w_last;
  logic                     w_mac_clr;
  logic                     w_mac_en;
  logic signed [BYTE_W-1:0] w_a;
  logic signed [BYTE_W-1:0] w_b;
  logic signed [ACC_W-1:0]  w_acc;

  assign w_xfer    = bus.in_valid && r_in_ready;
  assign w_last    = (r_idx == IDX_LAST);
  assign w_mac_clr = (r_state == LOAD_B) && w_xfer;
  assign w_mac_en  = (r_state == MAC);
  assign w_a       = r_w[r_idx];
  assign w_b       = r_x[r_idx];

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign busy          = r_busy;

  tinyneuron_mac #(.ACC_W(ACC_W)) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_load (w_mac_clr),
    .en       (w_mac_en),
    .bias     ($signed(bus.in_data)),
    .a        (w_a),
    .b        (w_b),
    .acc      (w_acc)
  );

  // Sequencer FSM with index counter, register files and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_W;
      r_idx       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      for (int i = 0; i < int'(N_INPUTS); i++) begin
        r_w[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      case (r_state)
        LOAD_W: begin
          if (w_xfer) begin
            r_w[r_idx] <= $signed(bus.in_data);
            r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) r_state <= LOAD_X;
          end
        end
        LOAD_X: begin
          if (w_xfer) begin
            r_x[r_idx] <= $signed(bus.in_data);
            r_idx      <= w_last ? '0 : r_idx + IDX_W'(1);
            if (w_last) r_state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_xfer) begin
            r_idx      <= '0;
            r_state    <= MAC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        MAC: begin
          r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
          if (w_last) r_state <= ACT;
        end
        ACT: begin
          r_out_data  <= sat_u8(SAT_W'(w_acc), SHIFT);
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= bus.reload_w ? LOAD_W : LOAD_X;
          end
        end
        default: begin
          r_state <= LOAD_W;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinyneuron_seq.sv
// Self-checking bench for tinyneuron_seq: transaction-level model plus directed and random evaluations.
module tb_tinyneuron_seq;

  localparam int N     = 4;
  localparam int ACC_W = 20;
  localparam int SHIFT = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  tinyneuron_seq_if bus ();

  tinyneuron_seq #(.N_INPUTS(N), .ACC_W(ACC_W), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // ---------------- behavioural model (transaction level) ----------------
  bit         m_loading = 1'b1;  // model expects to accept bytes
  bit         m_with_w  = 1'b1;  // current load includes weights
  bit         m_valid   = 1'b0;
  int         m_cnt     = 0;     // bytes taken in current load
  int         m_wait    = 0;     // cycles left until result appears
  logic [7:0] m_out     = '0;
  logic [7:0] m_res     = '0;
  int         mw [N];
  int         mx [N];

  function automatic logic [7:0] model_out(input int bias);
    longint acc;
    acc = bias;
    for (int i = 0; i < N; i++) acc += longint'(mw[i] * mx[i]);
    if (acc < 0) return 8'd0;
    acc = acc >>> SHIFT;
    if (acc > 255) return 8'd255;
    return 8'(acc);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading <= 1'b1;
      m_with_w  <= 1'b1;
      m_valid   <= 1'b0;
      m_cnt     <= 0;
      m_wait    <= 0;
      for (int i = 0; i < N; i++) begin
        mw[i] <= 0;
        mx[i] <= 0;
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_out   <= m_res;
      end
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid   <= 1'b0;
        m_loading <= 1'b1;
        m_with_w  <= bus.reload_w;
        m_cnt     <= 0;
      end
    end else if (m_loading && bus.in_valid) begin
      if (m_with_w && m_cnt < N)
        mw[m_cnt] <= int'($signed(bus.in_data));
      else if (m_cnt < (m_with_w ? 2 * N : N))
        mx[m_cnt - (m_with_w ? N : 0)] <= int'($signed(bus.in_data));
      else begin
        m_res     <= model_out(int'($signed(bus.in_data)));
        m_loading <= 1'b0;
        m_wait    <= N + 1;
      end
      m_cnt <= m_cnt + 1;
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 32'(bus.in_ready), 32'(m_loading));
      check("out_valid", 32'(bus.out_valid), 32'(m_valid));
      check("busy", 32'(busy), 32'(m_wait > 0));
      if (m_valid) check("out_data", 32'(bus.out_data), 32'(m_out));
    end
  end

  // ---------------- driver ----------------
  bit         gaps       = 1'b0;
  bit         oready_rand = 1'b0;
  bit         drv_with_w = 1'b1;
  longint     last_bias  = 0;
  longint     prev_bias  = 0;
  logic [7:0] tw [N];
  logic [7:0] tx [N];
  logic [7:0] tbias;

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    if (gaps && $urandom_range(0, 2) == 0) begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) check("in_accept_timeout", 32'(0), 32'(1));
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  // Send one evaluation, wait for out_valid, check latency/busy and optional literal result.
  task automatic load_eval(input int exp, input string nm);
    int lat, nbusy;
    if (drv_with_w) for (int i = 0; i < N; i++) send_byte(tw[i]);
    for (int i = 0; i < N; i++) send_byte(tx[i]);
    send_byte(tbias);
    prev_bias = last_bias;
    last_bias = cyc;
    lat   = 0;
    nbusy = 0;
    while (!bus.out_valid && lat < 50) begin
      if (busy) nbusy++;
      if (oready_rand) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    check({nm, "_latency"}, 32'(lat), 32'(N + 1));
    check({nm, "_busy_cycles"}, 32'(nbusy), 32'(N + 1));
    if (exp >= 0) check({nm, "_result"}, 32'(bus.out_data), 32'(exp));
  endtask

  task automatic do_handshake(input bit next_reload);
    int n;
    bit hs;
    bus.reload_w = next_reload;
    n  = 0;
    hs = 1'b0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = bus.out_ready && bus.out_valid;
      @(posedge clk); #1;
      if (!hs && oready_rand) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (!hs) check("handshake_timeout", 32'(0), 32'(1));
    drv_with_w   = next_reload;
    bus.reload_w = 1'($urandom);
  endtask

  task automatic set_all(input logic [7:0] w, input logic [7:0] x, input logic [7:0] b);
    for (int i = 0; i < N; i++) begin
      tw[i] = w;
      tx[i] = x;
    end
    tbias = b;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] held;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.reload_w  = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_out_data", 32'(bus.out_data), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 1*10+2*10+3*10+4*10 = 100
    for (int i = 0; i < N; i++) tw[i] = 8'(i + 1);
    for (int i = 0; i < N; i++) tx[i] = 8'd10;
    tbias = 8'd0;
    load_eval(100, "basic");
    do_handshake(1'b0);

    // Weight reuse: 1+2+3+4+5 = 15, twice back-to-back for the minimum period
    for (int i = 0; i < N; i++) tx[i] = 8'd1;
    tbias = 8'd5;
    load_eval(15, "reuse1");
    do_handshake(1'b0);
    load_eval(15, "reuse2");
    check("min_period", 32'(last_bias - prev_bias), 32'(11));
    do_handshake(1'b1);

    // ReLU: -(1+2+3+4)*10 < 0
    for (int i = 0; i < N; i++) tw[i] = 8'(-(i + 1));
    for (int i = 0; i < N; i++) tx[i] = 8'd10;
    tbias = 8'd0;
    load_eval(0, "relu");
    do_handshake(1'b1);

    // Saturation at positive and negative extremes
    set_all(8'd127, 8'd127, 8'd127);
    load_eval(255, "sat_pos");
    do_handshake(1'b1);
    set_all(8'h80, 8'h80, 8'd0);
    load_eval(255, "sat_neg");
    do_handshake(1'b1);

    // Backpressure: 4*3*5 + 7 = 67 held for 10 cycles
    set_all(8'd3, 8'd5, 8'd7);
    bus.out_ready = 1'b0;
    load_eval(67, "bp");
    held = bus.out_data;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'(1));
      check("bp_out_stable", 32'(bus.out_data), 32'(held));
      check("bp_in_ready", 32'(bus.in_ready), 32'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    do_handshake(1'b1);
    check("bp_after_valid", 32'(bus.out_valid), 32'(0));
    check("bp_after_ready", 32'(bus.in_ready), 32'(1));
    @(posedge clk); #1;
    check("bp_single_hs", 32'(bus.out_valid), 32'(0));

    // Reset during the second MAC cycle
    set_all(8'd9, 8'd9, 8'd9);
    for (int i = 0; i < N; i++) send_byte(tw[i]);
    for (int i = 0; i < N; i++) send_byte(tx[i]);
    send_byte(tbias);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'(0));
    check("arst_in_ready", 32'(bus.in_ready), 32'(1));
    check("arst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drv_with_w = 1'b1;
    @(posedge clk); #1;
    set_all(8'd1, 8'd2, 8'd0);
    load_eval(8, "post_reset");
    do_handshake(1'($urandom_range(0, 1)));

    // Randomized evaluations with input gaps and output backpressure
    gaps        = 1'b1;
    oready_rand = 1'b1;
    for (int e = 0; e < 40; e++) begin
      for (int i = 0; i < N; i++) begin
        if (e % 2 == 0) begin
          tw[i] = 8'($urandom_range(0, 28) - 8);
          tx[i] = 8'($urandom_range(0, 15));
        end else begin
          tw[i] = 8'($urandom);
          tx[i] = 8'($urandom);
        end
      end
      tbias = 8'($urandom);
      load_eval(-1, "rand");
      do_handshake(1'($urandom_range(0, 1)));
    end

    gaps          = 1'b0;
    oready_rand   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
